// File: rtl/seq_divider_32bit.sv
// 32-bit unsigned restoring divider: one quotient bit per clock, quotient
// accumulates in the dividend shift register, remainder in a 33-bit P.
module seq_divider_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg;
    logic [31:0] dvd_reg;
    logic [31:0] dsr_reg;
    logic [32:0] p_reg;
    logic [5:0]  cnt_reg;
    logic        zero_pend_reg;

    logic [32:0] shifted;
    logic [32:0] dsr_inv;
    logic [32:0] trial;
    logic        qbit;
    logic [32:0] p_next;
    logic [31:0] dvd_next;

    assign shifted = {p_reg[31:0], dvd_reg[31]};

    // Trial subtract as A + ~{0,B} + 1; the zero-extension bit inverts to 1.
    genvar gi;
    generate
        for (gi = 0; gi < 33; gi++) begin : g_inv
            if (gi < 32) begin : g_lo
                assign dsr_inv[gi] = ~dsr_reg[gi];
            end else begin : g_hi
                assign dsr_inv[gi] = 1'b1;
            end
        end
    endgenerate

    assign trial    = shifted + dsr_inv + 33'd1;
    assign qbit     = ~trial[32];
    assign p_next   = qbit ? trial : shifted;
    assign dvd_next = {dvd_reg[30:0], qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            p_reg         <= '0;
            cnt_reg       <= '0;
            zero_pend_reg <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            div_by_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (zero_pend_reg) begin
                // Divide-by-zero waits one edge so done lands at E1 like a short run.
                zero_pend_reg <= 1'b0;
                state_reg     <= DONE;
                done          <= 1'b1;
                quotient      <= 32'hFFFF_FFFF;
                remainder     <= dvd_reg;
                div_by_zero   <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start) begin
                            dvd_reg <= dividend;
                            dsr_reg <= divisor;
                            p_reg   <= '0;
                            cnt_reg <= '0;
                            if (divisor == 32'd0) begin
                                zero_pend_reg <= 1'b1;
                                state_reg     <= IDLE;
                            end else begin
                                state_reg <= RUN;
                                busy      <= 1'b1;
                            end
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    RUN: begin
                        p_reg   <= p_next;
                        dvd_reg <= dvd_next;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == 6'd31) begin
                            state_reg   <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= dvd_next;
                            remainder   <= p_next[31:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
